// File: rtl/br_ctrl_pkg.sv
// Shared types and defaults for the bias+ReLU stream controller.
// Holds the sequencer state encoding and the default bus/counter widths.
package br_ctrl_pkg;

  localparam int BR_BUSWIDTH_DEF = 512;
  localparam int BR_CNT_W_DEF    = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    WAIT   = 3'd3,
    EMIT   = 3'd4,
    FINISH = 3'd5
  } br_state_e;

endpackage

// File: rtl/bias_relu_stream_ctrl.sv
// Sequencer that feeds the bias+ReLU engine one beat at a time and streams
// the engine results to the write-back DMA. Exactly one beat is in flight.
// Optional feature: define BR_TIMEOUT_EN to enable the engine-done watchdog,
// which aborts the job after DONE_TIMEOUT cycles in WAIT without br_done_i.
// BUSWIDTH is expected to be a multiple of 32 (engine lane width).
module bias_relu_stream_ctrl
  import br_ctrl_pkg::*;
#(
  parameter int BUSWIDTH     = BR_BUSWIDTH_DEF,
  parameter int CNT_W        = BR_CNT_W_DEF,
  parameter int DONE_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                cfg_start_i,
  input  logic [CNT_W-1:0]    cfg_beats_i,
  input  logic [BUSWIDTH-1:0] in_data_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  output logic [BUSWIDTH-1:0] br_data_o,
  output logic                br_data_en_o,
  output logic                br_start_o,
  input  logic                br_done_i,
  input  logic [BUSWIDTH-1:0] br_result_i,
  output logic [BUSWIDTH-1:0] out_data_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_timeout_o
);

  br_state_e        state;
  logic [CNT_W-1:0] remaining;
  logic             timeout_hit;

  // Upstream is only accepted while fetching; this is the one unregistered output.
  assign in_ready_o = (state == FETCH);

`ifdef BR_TIMEOUT_EN
  localparam int TW = $clog2(DONE_TIMEOUT + 1);

  logic [TW-1:0] wait_cnt;

  // Abort fires on the DONE_TIMEOUT-th consecutive WAIT cycle without a done.
  assign timeout_hit = (state == WAIT) && !br_done_i &&
                       (wait_cnt == TW'(DONE_TIMEOUT - 1));

  // Watchdog counts WAIT cycles and restarts from zero whenever WAIT is left.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wait_cnt <= '0;
    end else if ((state == WAIT) && !br_done_i) begin
      wait_cnt <= wait_cnt + TW'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  // Sticky error flag, cleared only when a new job is accepted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_timeout_o <= 1'b0;
    end else if ((state == IDLE) && cfg_start_i) begin
      err_timeout_o <= 1'b0;
    end else if (timeout_hit) begin
      err_timeout_o <= 1'b1;
    end
  end
`else
  logic [31:0] timeout_unused;

  assign timeout_unused = 32'(DONE_TIMEOUT);
  assign timeout_hit    = 1'b0;
  assign err_timeout_o  = 1'b0;
`endif

  // Main sequencer: state, beat counter and all registered stream/engine outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      remaining    <= '0;
      br_data_o    <= '0;
      br_data_en_o <= 1'b0;
      br_start_o   <= 1'b0;
      out_data_o   <= '0;
      out_valid_o  <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      br_data_en_o <= 1'b0;
      br_start_o   <= 1'b0;
      done_o       <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_start_i) begin
            if (cfg_beats_i != '0) begin
              remaining <= cfg_beats_i;
              busy_o    <= 1'b1;
              state     <= FETCH;
            end else begin
              done_o <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (in_valid_i) begin
            br_data_o    <= in_data_i;
            br_data_en_o <= 1'b1;
            br_start_o   <= 1'b1;
            state        <= LOAD;
          end
        end
        LOAD: begin
          state <= WAIT;
        end
        WAIT: begin
          if (br_done_i) begin
            out_data_o  <= br_result_i;
            out_valid_o <= 1'b1;
            state       <= EMIT;
          end else if (timeout_hit) begin
            remaining <= '0;
            done_o    <= 1'b1;
            state     <= FINISH;
          end
        end
        EMIT: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            remaining   <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) begin
              done_o <= 1'b1;
              state  <= FINISH;
            end else begin
              state <= FETCH;
            end
          end
        end
        FINISH: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
